// File: rtl/prog_clk_div.sv
`default_nettype none
// ============================================================================
// Module      : prog_clk_div
// Description : Multi-channel synchronous clock divider. Each channel has a
//               runtime-programmable integer ratio and produces a registered
//               divided-clock level plus a one-cycle tick enable. Ratio
//               changes are deferred to the channel's terminal count so the
//               outputs never glitch; a global sync restarts all channels in
//               phase.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_clk_div #(
    parameter int N_CH      = 4,
    parameter int DIV_W     = 8,
    parameter int RESET_DIV = 2,
    localparam int c_CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_CH-1:0]   en,
    input  logic              sync,
    input  logic              cfg_valid,
    input  logic [c_CH_W-1:0] cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    output logic [N_CH-1:0]   cfg_pending,
    output logic [N_CH-1:0]   clk_out,
    output logic [N_CH-1:0]   tick
);

    localparam logic [DIV_W-1:0] c_RESET_DIV = DIV_W'(RESET_DIV);

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [DIV_W-1:0] r_cnt;
            logic [DIV_W-1:0] r_div;
            logic [DIV_W-1:0] r_shadow;
            logic             r_pend;
            logic             r_clk;
            logic             r_tick;

            logic             w_active;
            logic [DIV_W-1:0] w_last;
            logic             w_term;
            logic [DIV_W:0]   w_half;
            logic             w_lo_half;
            logic             w_wr;

            // A zero ratio parks the channel exactly like a cleared enable.
            assign w_active  = en[gi] && (r_div != '0);
            assign w_last    = r_div - 1'b1;
            assign w_term    = w_active && (r_cnt == w_last);
            // High phase length ceil(D/2), widened so D = 2^DIV_W-1 cannot wrap.
            assign w_half    = ({1'b0, r_div} + 1'b1) >> 1;
            assign w_lo_half = ({1'b0, r_cnt} < w_half);
            assign w_wr      = cfg_valid && (cfg_ch == c_CH_W'(gi));

            // Counter, ratio shadowing and registered output decode for one channel.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    r_cnt    <= '0;
                    r_div    <= c_RESET_DIV;
                    r_shadow <= '0;
                    r_pend   <= 1'b0;
                    r_clk    <= 1'b0;
                    r_tick   <= 1'b0;
                end else begin
                    // Outputs always decode the counter value before this edge.
                    r_clk  <= w_active && w_lo_half;
                    r_tick <= w_term;

                    if (sync || !w_active || w_term) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end

                    if (w_wr && (!w_active || w_term)) begin
                        // Safe point right now: load the new ratio directly.
                        r_div  <= cfg_div;
                        r_pend <= 1'b0;
                    end else begin
                        if (r_pend && (w_term || !w_active || sync)) begin
                            r_div  <= r_shadow;
                            r_pend <= 1'b0;
                        end
                        // A newer write lands in the shadow; last write wins.
                        if (w_wr) begin
                            r_shadow <= cfg_div;
                            r_pend   <= 1'b1;
                        end
                    end
                end
            end

            assign clk_out[gi]     = r_clk;
            assign tick[gi]        = r_tick;
            assign cfg_pending[gi] = r_pend;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_prog_clk_div.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_clk_div
// Description : Self-checking bench for prog_clk_div. A per-channel ratio
//               model predicts every output on every cycle; directed phases
//               pin known waveforms, then randomized traffic runs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_clk_div;

    localparam int N_CH      = 5;
    localparam int DIV_W     = 8;
    localparam int RESET_DIV = 2;
    localparam int c_CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic              clk;
    logic              reset;
    logic [N_CH-1:0]   en;
    logic              sync;
    logic              cfg_valid;
    logic [c_CH_W-1:0] cfg_ch;
    logic [DIV_W-1:0]  cfg_div;
    logic [N_CH-1:0]   cfg_pending;
    logic [N_CH-1:0]   clk_out;
    logic [N_CH-1:0]   tick;

    prog_clk_div #(
        .N_CH      (N_CH),
        .DIV_W     (DIV_W),
        .RESET_DIV (RESET_DIV)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .sync        (sync),
        .cfg_valid   (cfg_valid),
        .cfg_ch      (cfg_ch),
        .cfg_div     (cfg_div),
        .cfg_pending (cfg_pending),
        .clk_out     (clk_out),
        .tick        (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: phase within the period, active ratio, shadow, pending.
    int m_c [N_CH];
    int m_d [N_CH];
    int m_s [N_CH];
    bit m_p [N_CH];
    logic [N_CH-1:0] e_clk, e_tick, e_pend;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Advance the model by one rising edge using the inputs presented to it.
    function automatic void model_edge();
        bit act, term, wr;
        for (int i = 0; i < N_CH; i++) begin
            if (!reset) begin
                m_c[i] = 0; m_d[i] = RESET_DIV; m_s[i] = 0; m_p[i] = 1'b0;
                e_clk[i] = 1'b0; e_tick[i] = 1'b0; e_pend[i] = 1'b0;
            end else begin
                act  = en[i] && (m_d[i] != 0);
                term = act && (m_c[i] == m_d[i] - 1);
                wr   = cfg_valid && (int'(cfg_ch) == i);
                e_clk[i]  = act && (m_c[i] < (m_d[i] + 1) / 2);
                e_tick[i] = term;
                if (sync || !act) m_c[i] = 0;
                else              m_c[i] = (m_c[i] + 1) % m_d[i];
                if (wr && (!act || term)) begin
                    m_d[i] = int'(cfg_div); m_p[i] = 1'b0;
                end else begin
                    if (m_p[i] && (term || !act || sync)) begin
                        m_d[i] = m_s[i]; m_p[i] = 1'b0;
                    end
                    if (wr) begin
                        m_s[i] = int'(cfg_div); m_p[i] = 1'b1;
                    end
                end
                e_pend[i] = m_p[i];
            end
        end
    endfunction

    // One clock: model follows the edge, then every output is compared.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("clk_out", 32'(clk_out), 32'(e_clk));
        chk("tick", 32'(tick), 32'(e_tick));
        chk("cfg_pending", 32'(cfg_pending), 32'(e_pend));
    endtask

    task automatic do_reset();
        reset = 1'b0; en = '0; sync = 1'b0; cfg_valid = 1'b0;
        step();
        reset = 1'b1;
    endtask

    task automatic wr_cfg(input int ch, input int d);
        cfg_valid = 1'b1; cfg_ch = c_CH_W'(ch); cfg_div = DIV_W'(d);
        step();
        cfg_valid = 1'b0;
    endtask

    logic [15:0] sc, st, sp;
    int coinc, first_co;

    initial begin
        reset = 1'b0; en = '0; sync = 1'b0; cfg_valid = 1'b0;
        cfg_ch = '0; cfg_div = '0;
        repeat (3) step();
        chk("reset_outs", 32'({clk_out, tick, cfg_pending}), 32'd0);

        // Reset ratio 2 on channel 0.
        reset = 1'b1; en = N_CH'(1);
        sc = '0; st = '0;
        sc[0] = clk_out[0]; st[0] = tick[0];
        for (int k = 1; k < 5; k++) begin
            step(); sc[k] = clk_out[0]; st[k] = tick[0];
        end
        chk("t1_clk", 32'(sc[4:0]), 32'(5'b01010));
        chk("t1_tick", 32'(st[4:0]), 32'(5'b10100));
        chk("t1_others", 32'(clk_out[N_CH-1:1] | tick[N_CH-1:1]), 32'd0);

        // Ratio 4 on channel 1, written while idle then enabled.
        do_reset();
        wr_cfg(1, 4);
        chk("t2_immediate", 32'(cfg_pending[1]), 32'd0);
        en = N_CH'(2);
        sc = '0; st = '0;
        sc[0] = clk_out[1]; st[0] = tick[1];
        for (int k = 1; k < 9; k++) begin
            step(); sc[k] = clk_out[1]; st[k] = tick[1];
        end
        chk("t2_clk", 32'(sc[8:0]), 32'(9'b001100110));
        chk("t2_tick", 32'(st[8:0]), 32'(9'b100010000));

        // Channel 2 running at 3, ratio 5 written mid-period.
        do_reset();
        wr_cfg(2, 3);
        en = N_CH'(4);
        repeat (3) step();
        chk("t3_phase", 32'(m_c[2]), 32'd0);
        wr_cfg(2, 5);
        sc = '0; st = '0; sp = '0;
        sc[0] = clk_out[2]; st[0] = tick[2]; sp[0] = cfg_pending[2];
        for (int k = 1; k < 8; k++) begin
            step(); sc[k] = clk_out[2]; st[k] = tick[2]; sp[k] = cfg_pending[2];
        end
        chk("t3_clk", 32'(sc[7:0]), 32'(8'b00111011));
        chk("t3_tick", 32'(st[7:0]), 32'(8'b10000100));
        chk("t3_pend", 32'(sp[7:0]), 32'(8'b00000011));

        // Channel 3: ratio 1 then ratio 0.
        do_reset();
        en = N_CH'(8);
        repeat (3) step();
        wr_cfg(3, 1);
        repeat (2) step();
        chk("t4_d1_clk", 32'(clk_out[3]), 32'd1);
        chk("t4_d1_tick", 32'(tick[3]), 32'd1);
        wr_cfg(3, 0);
        chk("t4_apply_edge", 32'({clk_out[3], tick[3]}), 32'd3);
        step();
        chk("t4_d0_outs", 32'({clk_out[3], tick[3], cfg_pending[3]}), 32'd0);
        step();
        chk("t4_d0_hold", 32'({clk_out[3], tick[3]}), 32'd0);

        // Ratios 2/4/6 with staggered enables, then sync.
        do_reset();
        wr_cfg(1, 4);
        wr_cfg(2, 6);
        en = N_CH'(1); repeat (2) step();
        en = N_CH'(3); repeat (3) step();
        en = N_CH'(7); repeat (5) step();
        for (int k = 0; k < 4 && m_c[0] != 0; k++) step();
        chk("t5_phase", 32'(m_c[0]), 32'd0);
        wr_cfg(0, 2);
        chk("t5_pending", 32'(cfg_pending[0]), 32'd1);
        sync = 1'b1; step(); sync = 1'b0;
        chk("t5_sync_apply", 32'(cfg_pending[0]), 32'd0);
        coinc = 0; first_co = 0;
        for (int k = 1; k <= 24; k++) begin
            step();
            if (tick[0] && tick[1] && tick[2]) begin
                coinc++;
                if (first_co == 0) first_co = k;
            end
        end
        chk("t5_coinc", 32'(coinc), 32'd2);
        chk("t5_first", 32'(first_co), 32'd12);

        // Reset with a pending write and an out-of-range write.
        wr_cfg(1, 9);
        chk("t6_pending", 32'(cfg_pending[1]), 32'd1);
        reset = 1'b0; cfg_valid = 1'b1; cfg_ch = c_CH_W'(N_CH); cfg_div = 8'd7;
        step();
        chk("t6_reset_outs", 32'({clk_out, tick, cfg_pending}), 32'd0);
        reset = 1'b1; en = '1;
        step();
        cfg_valid = 1'b0;
        chk("t6_clk_hi", 32'(clk_out), 32'({N_CH{1'b1}}));
        step();
        chk("t6_tick_all", 32'(tick), 32'({N_CH{1'b1}}));
        chk("t6_clk_lo", 32'(clk_out), 32'd0);

        // Randomized traffic, including out-of-range channels.
        for (int n = 0; n < 3000; n++) begin
            reset     = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 15) == 0) en = N_CH'($urandom);
            sync      = ($urandom_range(0, 29) == 0);
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_ch    = c_CH_W'($urandom_range(0, (1 << c_CH_W) - 1));
            cfg_div   = ($urandom_range(0, 3) == 0) ? DIV_W'($urandom)
                                                    : DIV_W'($urandom_range(0, 7));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prog_clk_div.md
Name: prog_clk_div

Overview:
- Parametrised, fully synchronous multi-channel clock divider. Successor to the fixed ripple divide-by-2/4/8/16 chain.
- N_CH independent channels, each with a runtime-programmable integer ratio. Every channel produces a registered divided-clock level and a one-cycle tick enable.
- All logic runs on the single system clock. Downstream logic uses the tick outputs as clock enables rather than as clocks.
- Ratio changes are glitch-free: they take effect at the channel's terminal count. A global sync input phase-aligns all channels.

Parameters:
- N_CH, 4, number of divider channels (1..16)
- DIV_W, 8, width of a divide ratio; legal ratios 0..2^DIV_W-1
- RESET_DIV, 2, active ratio of every channel after reset (must be < 2^DIV_W)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- en  in  N_CH  per-channel enable
- sync  in  1  restart all channel counters in phase
- cfg_valid  in  1  ratio write strobe, single cycle
- cfg_ch  in  $clog2(N_CH) (min 1)  target channel of the write
- cfg_div  in  DIV_W  new ratio D for the target channel
- cfg_pending  out  N_CH  write accepted but not yet applied
- clk_out  out  N_CH  divided clock level, registered
- tick  out  N_CH  one-cycle pulse per divided period, registered

Behaviour:
- Per-channel state: counter c (DIV_W bits), active ratio D, shadow ratio S, pending flag P. H = (D+1)>>1, computed at DIV_W+1 bits.
- Reset (reset==0 at a rising edge):
  - c=0, D=RESET_DIV, P=0.
  - clk_out=0, tick=0, cfg_pending=0.
  - Applies from any state; pending writes are discarded.
- Channel active when en[i]==1 and D!=0. Each active cycle:
  - next c = (c==D-1) ? 0 : c+1.
  - clk_out[i] <= (c < H).
  - tick[i] <= (c == D-1).
  - Outputs lag the counter by one cycle.
- Inactive channel (en[i]==0 or D==0):
  - c <= 0.
  - clk_out[i] <= 0 and tick[i] <= 0 on the next edge.
  - Re-enabling restarts from c=0.
- Duty cycle: high for ceil(D/2) of every D cycles. D even gives 50%. D=1 gives clk_out constant 1 and tick every cycle.
- Ratio write (cfg_valid==1, cfg_ch < N_CH):
  - If the target channel is inactive, or at terminal count (c==D-1) this cycle: D <= cfg_div immediately, P <= 0.
  - Otherwise: S <= cfg_div, P <= 1.
  - A write while P==1 overwrites S; the last write wins.
  - cfg_ch >= N_CH: write ignored.
- Pending apply: when P==1 and the channel hits terminal count, or becomes inactive, or sync is asserted: D <= S, P <= 0. The counter wraps to 0 in the same edge.
- sync==1:
  - All channel counters <= 0, overriding normal increment.
  - Outputs for that edge still decode the pre-sync c.
  - Pending ratios are applied.
  - Inactive channels are unaffected beyond c=0.
- Priority per channel, highest first: reset > sync > inactive > terminal-count wrap > increment.
- cfg_pending[i] = P, registered. It deasserts on the same edge that loads D.
- No combinational path from any input to any output.

Test Plan:
- Reset release, en=4'b0001, D=RESET_DIV=2 → clk_out[0] from the first post-reset cycle: 0,1,0,1,... and tick[0]: 0,0,1,0,1,... Other channels stay 0.
- Write ch1 D=4, then en[1]=1 from reset → clk_out[1]: 0,1,1,0,0,1,1,0,0. tick[1] high at cycles 4 and 8 only.
- Ch2 running D=3, write D=5 mid-period:
  - cfg_pending[2]=1 until the current period completes.
  - The period containing the write is still 3 cycles, then 5-cycle periods (high 3, low 2).
  - cfg_pending[2] clears on the switch edge.
- Write D=1 then D=0 to ch3:
  - D=1: tick[3] every cycle, clk_out[3]=1.
  - D=0: both outputs 0 one cycle after the apply edge, and cfg_pending[3]=0 afterward.
- Channels at D=2,4,6 with staggered enables, pulse sync → all counters 0 on the same edge. Ticks then coincide every 12 cycles; a pending write to ch0 is applied at sync.
- Assert reset low mid-period with a pending write and a cfg_ch=N_CH write → all outputs 0 next cycle, D=2 everywhere, cfg_pending=0. The out-of-range write has no effect.
